instr_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage of the core. Holds the architectural PC and computes the sequential next PC through the PC+4 adder. Issues one outstanding read at a time to instruction memory and hands {pc, instruction} to decode over a valid/ready handshake. Decode or the trap logic can redirect the PC at any time; in-flight fetches are discarded.

---
 rtl/instr_fetch_unit_pkg.sv | 21 ++
 rtl/instr_fetch_unit_pc_adder.sv | 9 +
 rtl/instr_fetch_unit.sv | 111 +++++++++++
 tb/tb_instr_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, reset PC
// default and the NOP word presented on a misaligned fetch target.
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_adder.sv
// 32-bit sequential PC incrementer (PC + 4, wraps modulo 2^32).
module instr_fetch_unit_pc_adder (
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register and instruction-fetch FSM: one outstanding imem read, result
// handed to decode over valid/ready; redirects discard in-flight fetches.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault,
  input  logic        if_ready
);

  fetch_state_t state_q, state_d, resume;
  logic [31:0]  pc_q, pc_d, pc_plus4;
  logic         fault_pend_q;
  logic         capture;
  logic         enter_fault;

  instr_fetch_unit_pc_adder u_pc_adder (
    .pc       (pc_q),
    .pc_plus4 (pc_plus4)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    capture     = 1'b0;
    resume      = REQ;
    enter_fault = 1'b0;

    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (imem_req_ready) state_d = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = HOLD;
          pc_d    = pc_plus4;
          capture = 1'b1;
        end
      end
      HOLD:    if (if_ready) state_d = REQ;
      DRAIN: begin
        if (imem_rsp_valid) state_d = is_misaligned(pc_q) ? FAULT : REQ;
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      capture = 1'b0;
      resume  = is_misaligned(redirect_pc) ? FAULT : REQ;
      case (state_q)
        REQ:     state_d = imem_req_ready ? DRAIN : resume;
        WAIT:    state_d = imem_rsp_valid ? resume : DRAIN;
        // A response landing alongside a redirect still retires the drain,
        // otherwise the single outstanding response would be lost forever.
        DRAIN:   state_d = imem_rsp_valid ? resume : DRAIN;
        default: state_d = resume;
      endcase
    end

    enter_fault = (state_d == FAULT) && ((state_q != FAULT) || redirect_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      if_pc        <= '0;
      if_instr     <= '0;
      if_fault     <= 1'b0;
      fault_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;

      if (capture) begin
        if_pc    <= pc_q;
        if_instr <= imem_rsp_data;
        if_fault <= 1'b0;
      end else if (enter_fault) begin
        if_pc    <= pc_d;
        if_instr <= NOP_INSTR;
        if_fault <= 1'b1;
      end

      if (enter_fault) begin
        fault_pend_q <= 1'b1;
      end else if ((state_d != FAULT) || if_ready) begin
        fault_pend_q <= 1'b0;
      end
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == HOLD) || ((state_q == FAULT) && fault_pend_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed sequences, a redirect
// vector table, and a randomized run against a transaction-level model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
  logic        if_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault),
    .if_ready       (if_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } xfer_t;

  typedef struct {
    logic [31:0] target;
    logic        fault;
    logic [31:0] next_addr;
  } vec_t;

  xfer_t       exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_pc;
  logic        out_ok;
  logic        chk_en;
  int unsigned mem_cnt;
  logic [31:0] mem_addr;
  int unsigned ready_pct, dmin, dmax;
  int unsigned hs_count;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E77;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One clock cycle: drive memory, update the model from what this cycle
  // shows, then advance to just after the next rising edge.
  task automatic tick();
    logic  acc;
    xfer_t x;
    imem_rsp_valid = (mem_cnt == 1);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom();
    imem_req_ready = ($urandom_range(99) < ready_pct);
    acc = imem_req_valid && imem_req_ready;
    if (chk_en) begin
      if (if_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_if_valid", 32'(if_valid), 32'd0);
        end else begin
          chk("if_pc", if_pc, exp_q[0].pc);
          chk("if_instr", if_instr, exp_q[0].instr);
          chk("if_fault", 32'(if_fault), 32'(exp_q[0].fault));
          if (if_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end
      if (acc) begin
        if (exp_pc[1:0] != 2'b00) chk("req_while_faulted", 32'(imem_req_valid), 32'd0);
        else chk("req_addr", imem_req_addr, exp_pc);
        out_ok = 1'b1;
      end
      if (imem_rsp_valid) begin
        if (out_ok && !redirect_valid) begin
          x.pc = mem_addr; x.instr = mem_word(mem_addr); x.fault = 1'b0;
          exp_q.push_back(x);
          exp_pc = mem_addr + 32'd4;
        end
        out_ok = 1'b0;
      end
      if (redirect_valid) begin
        out_ok = 1'b0;
        exp_q.delete();
        exp_pc = redirect_pc;
        if (redirect_pc[1:0] != 2'b00) begin
          x.pc = redirect_pc; x.instr = NOP; x.fault = 1'b1;
          exp_q.push_back(x);
        end
      end
    end
    if (imem_rsp_valid) mem_cnt = 0;
    else if (mem_cnt > 1) mem_cnt--;
    if (acc) begin
      mem_cnt  = $urandom_range(dmax, dmin);
      mem_addr = imem_req_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int sel, input string name);
    for (int i = 0; i < 40; i++) begin
      if ((sel == 0) ? if_valid : imem_req_valid) break;
      tick();
    end
    chk(name, 32'((sel == 0) ? if_valid : imem_req_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    logic        prev_fault;
    logic [31:0] sv_pc, sv_instr, tgt;
    int unsigned hs0;

    vecs[0] = '{32'h0000_2000, 1'b0, 32'h0000_2004};
    vecs[1] = '{32'h0000_2002, 1'b1, 32'h0};
    vecs[2] = '{32'h0000_3000, 1'b0, 32'h0000_3004};
    vecs[3] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000};
    vecs[4] = '{32'h0000_0001, 1'b1, 32'h0};
    vecs[5] = '{32'h0000_0003, 1'b1, 32'h0};
    vecs[6] = '{32'h8000_0000, 1'b0, 32'h8000_0004};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    ready_pct = 100; dmin = 1; dmax = 1; mem_cnt = 0; mem_addr = '0;
    chk_en = 1'b0; out_ok = 1'b0; exp_pc = RST_PC; hs_count = 0;

    repeat (3) tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_fault", 32'(if_fault), 32'd0);

    rst = 1'b0; chk_en = 1'b1;
    tick();
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RST_PC);

    // Zero-wait memory, decode always ready: one instruction per 3 cycles.
    if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("zw_req_addr", imem_req_addr, RST_PC + 32'(4 * k));
      tick();
      chk("zw_wait_if_valid", 32'(if_valid), 32'd0);
      tick();
      chk("zw_if_valid", 32'(if_valid), 32'd1);
      chk("zw_if_pc", if_pc, RST_PC + 32'(4 * k));
      tick();
    end

    // Decode back-pressure.
    if_ready = 1'b0;
    tick(); tick();
    chk("bp_if_valid", 32'(if_valid), 32'd1);
    chk("bp_if_pc", if_pc, 32'h0000_010C);
    sv_pc = if_pc; sv_instr = if_instr;
    repeat (5) begin
      tick();
      chk("bp_hold_valid", 32'(if_valid), 32'd1);
      chk("bp_hold_pc", if_pc, sv_pc);
      chk("bp_hold_instr", if_instr, sv_instr);
      chk("bp_no_req", 32'(imem_req_valid), 32'd0);
    end
    if_ready = 1'b1;
    tick();
    chk("bp_next_req_addr", imem_req_addr, 32'h0000_0110);

    // Redirect while waiting on a slow response.
    dmin = 3; dmax = 3;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    chk("drain_no_req", 32'(imem_req_valid), 32'd0);
    wait_for(1, "drain_req_timeout");
    chk("drain_req_addr", imem_req_addr, 32'h0000_2000);

    // Redirect in the same cycle as the response.
    dmin = 2; dmax = 2;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2400;
    tick();
    redirect_valid = 1'b0;
    chk("rsp_redir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rsp_redir_req_addr", imem_req_addr, 32'h0000_2400);
    chk("rsp_redir_if_valid", 32'(if_valid), 32'd0);

    // Redirect vectors applied from HOLD (or from an idle FAULT).
    dmin = 1; dmax = 1;
    prev_fault = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!prev_fault) begin
        if_ready = 1'b0;
        wait_for(0, "vec_hold_timeout");
      end
      redirect_valid = 1'b1; redirect_pc = vecs[i].target;
      tick();
      redirect_valid = 1'b0;
      if (vecs[i].fault) begin
        chk("vec_fault_valid", 32'(if_valid), 32'd1);
        chk("vec_fault_flag", 32'(if_fault), 32'd1);
        chk("vec_fault_instr", if_instr, NOP);
        chk("vec_fault_pc", if_pc, vecs[i].target);
        chk("vec_fault_no_req", 32'(imem_req_valid), 32'd0);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        repeat (3) tick();
        chk("vec_fault_idle_valid", 32'(if_valid), 32'd0);
        chk("vec_fault_idle_req", 32'(imem_req_valid), 32'd0);
      end else begin
        chk("vec_req_valid", 32'(imem_req_valid), 32'd1);
        chk("vec_req_addr", imem_req_addr, vecs[i].target);
        chk("vec_no_valid", 32'(if_valid), 32'd0);
        wait_for(0, "vec_fetch_timeout");
        chk("vec_if_pc", if_pc, vecs[i].target);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        chk("vec_next_addr", imem_req_addr, vecs[i].next_addr);
      end
      prev_fault = vecs[i].fault;
    end

    // Reset in the middle of WAIT; the late response must be ignored.
    dmin = 3; dmax = 3;
    tick(); tick();
    chk_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_if_pc", if_pc, 32'd0);
    chk("mid_rst_if_instr", if_instr, 32'd0);
    chk("mid_rst_if_fault", 32'(if_fault), 32'd0);
    ready_pct = 0;
    tick(); tick();
    chk("late_rsp_req_valid", 32'(imem_req_valid), 32'd1);
    chk("late_rsp_req_addr", imem_req_addr, RST_PC);
    chk("late_rsp_if_valid", 32'(if_valid), 32'd0);
    chk("late_rsp_if_pc", if_pc, 32'd0);
    ready_pct = 100; dmin = 1; dmax = 1;
    exp_q.delete(); exp_pc = RST_PC; out_ok = 1'b0; chk_en = 1'b1;
    if_ready = 1'b0;
    wait_for(0, "post_rst_fetch_timeout");
    chk("post_rst_if_pc", if_pc, RST_PC);

    // Randomized traffic against the model.
    ready_pct = 60; dmin = 1; dmax = 4;
    for (int n = 0; n < 4000; n++) begin
      if_ready       = ($urandom_range(99) < 70);
      redirect_valid = ($urandom_range(99) < 4);
      tgt = 32'h0000_4000 + 32'($urandom_range(255)) * 32'd4;
      if ($urandom_range(99) < 10) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
      if ($urandom_range(99) < 20) tgt[1:0] = 2'($urandom_range(3, 1));
      redirect_pc = tgt;
      tick();
    end

    // Fetching must resume and flow after the random phase.
    ready_pct = 100; dmin = 1; dmax = 1; if_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
    tick();
    redirect_valid = 1'b0;
    hs0 = hs_count;
    for (int i = 0; i < 60; i++) begin
      if (hs_count - hs0 >= 5) break;
      tick();
    end
    chk("liveness", 32'(hs_count - hs0 >= 5), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
